load_stage: RTL

Parametrised input stage for the SHAKE/SHA-3 core. It accepts a header word and message words over a valid/ready stream and packs them into rate-sized blocks. Keccak padding (domain byte and final 0x80) is inserted internally. Completed blocks are queued in a BUF_DEPTH-slot block FIFO for the permutation stage. Messages may follow back-to-back: a new header is accepted as soon as the previous message's last block is committed, without waiting for the FIFO to drain.

---
 rtl/shake_pkg.sv | 45 ++++
 rtl/load_stage_if.sv | 24 ++
 rtl/block_fifo.sv | 59 +++++
 rtl/load_stage.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/shake_pkg.sv
// shake_pkg: shared mode type, rate/domain constants and FIFO entry layout for load_stage.
// SHA3 constants exist only when LOAD_SHA3_EN is defined.
package shake_pkg;

    typedef enum logic [1:0] {
        MODE_SHAKE128 = 2'd0,
        MODE_SHAKE256 = 2'd1,
        MODE_SHA3_256 = 2'd2,
        MODE_SHA3_512 = 2'd3
    } mode_t;

    localparam int MAX_RATE_WORDS = 21;
    localparam int BLOCK_W        = 64 * MAX_RATE_WORDS;

    localparam logic [7:0] DOM_SHAKE = 8'h1F;
`ifdef LOAD_SHA3_EN
    localparam logic [7:0] DOM_SHA3  = 8'h06;
`endif

    typedef struct packed {
        logic [BLOCK_W-1:0] data;
        mode_t              mode;
        logic               last;
        logic [29:0]        out_len;
    } block_entry_t;

    function automatic logic [4:0] rate_words(mode_t mode);
`ifdef LOAD_SHA3_EN
        case (mode)
            MODE_SHAKE128:                return 5'd21;
            MODE_SHAKE256, MODE_SHA3_256: return 5'd17;
            default:                      return 5'd9;
        endcase
`else
        return (mode == MODE_SHAKE128) ? 5'd21 : 5'd17;
`endif
    endfunction

`ifdef LOAD_SHA3_EN
    function automatic logic [7:0] domain_byte(mode_t mode);
        return mode[1] ? DOM_SHA3 : DOM_SHAKE;
    endfunction
`endif

endpackage

// File: rtl/load_stage_if.sv
// load_stage_if: header/message word stream into the load stage and the block stream out of it.
interface load_stage_if;
    import shake_pkg::*;

    logic               valid_in;
    logic [63:0]        data_in;
    logic               ready_out;
    logic               block_valid;
    logic               block_ready;
    logic [BLOCK_W-1:0] block_data;
    mode_t              block_mode;
    logic               block_last;
    logic [29:0]        block_out_len;

    modport master (
        output valid_in, data_in, block_ready,
        input  ready_out, block_valid, block_data, block_mode, block_last, block_out_len
    );

    modport slave (
        input  valid_in, data_in, block_ready,
        output ready_out, block_valid, block_data, block_mode, block_last, block_out_len
    );
endinterface

// File: rtl/block_fifo.sv
// block_fifo: DEPTH-entry queue of completed blocks; pushes are refused while full even if
// a pop happens in the same cycle.
module block_fifo
    import shake_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  block_entry_t push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output block_entry_t head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    block_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: storage is reset too, so block_data and friends read zero right after reset.
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/load_stage.sv
// load_stage: packs header + message words into padded rate-sized blocks for the Keccak core.
// Define LOAD_SHA3_EN to enable the SHA3-256/512 modes; otherwise header bit 63 is forced to 0.
module load_stage
    import shake_pkg::*;
#(
    parameter int BUF_DEPTH = 2,
    parameter int LEN_W     = 32
) (
    input logic         clk,
    input logic         rst,
    load_stage_if.slave bus
);

    typedef enum logic [2:0] {S_RESET, S_IDLE, S_LOAD, S_PAD, S_COMMIT} state_t;

    state_t state_q;
    state_t state_d;

    logic [MAX_RATE_WORDS-1:0][63:0] asm_q;
    logic [4:0]       word_idx;
    logic [LEN_W-1:0] remaining;
    logic             dom_done;
    logic             last_q;
    mode_t            mode_q;
    logic [29:0]      out_len_q;

    mode_t        hdr_mode;
    logic [7:0]   dom;
    logic [4:0]   last_idx;
    logic         accept;
    logic         push;
    logic         full;
    logic         empty;
    logic         rem_ge8;
    logic [63:0]  tail_word;
    block_entry_t push_entry;
    block_entry_t head_entry;

`ifdef LOAD_SHA3_EN
    assign hdr_mode = mode_t'(bus.data_in[63:62]);
    assign dom      = domain_byte(mode_q);
`else
    logic unused_hdr_bit;
    assign unused_hdr_bit = bus.data_in[63];
    assign hdr_mode       = mode_t'({1'b0, bus.data_in[62]});
    assign dom            = DOM_SHAKE;
`endif

    assign last_idx = rate_words(mode_q) - 5'd1;
    assign rem_ge8  = (remaining >= LEN_W'(8));
    assign accept   = bus.valid_in && bus.ready_out;
    assign push     = (state_q == S_COMMIT) && !full;

    // Final partial word: keep the message bytes, drop the rest, place D right after them.
    always_comb begin
        tail_word = '0;
        for (int b = 0; b < 8; b++) begin
            if (3'(b) < remaining[2:0])       tail_word[8*b +: 8] = bus.data_in[8*b +: 8];
            else if (3'(b) == remaining[2:0]) tail_word[8*b +: 8] = dom;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) state_q <= S_RESET;
        else     state_q <= state_d;
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves an output unassigned (no latches).
        state_d       = state_q;
        bus.ready_out = 1'b0;
        case (state_q)
            S_RESET: state_d = S_IDLE;
            S_IDLE: begin
                bus.ready_out = 1'b1;
                if (bus.valid_in)
                    state_d = (bus.data_in[LEN_W-1:0] != '0) ? S_LOAD : S_PAD;
            end
            S_LOAD: begin
                bus.ready_out = 1'b1;
                // A partial word already carries D, so 0x80 still fits this block even at R-1.
                if (bus.valid_in) begin
                    if (!rem_ge8)                        state_d = S_PAD;
                    else if (word_idx == last_idx)       state_d = S_COMMIT;
                    else if (remaining == LEN_W'(8))     state_d = S_PAD;
                end
            end
            S_PAD: state_d = S_COMMIT;
            S_COMMIT: begin
                if (!full)
                    state_d = last_q ? S_IDLE : ((remaining == '0) ? S_PAD : S_LOAD);
            end
            default: state_d = S_RESET;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_q     <= '0;
            word_idx  <= '0;
            remaining <= '0;
            dom_done  <= 1'b0;
            last_q    <= 1'b0;
            mode_q    <= MODE_SHAKE128;
            out_len_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (accept) begin
                    mode_q    <= hdr_mode;
                    out_len_q <= bus.data_in[61:32];
                    remaining <= bus.data_in[LEN_W-1:0];
                    dom_done  <= 1'b0;
                    word_idx  <= '0;
                    last_q    <= 1'b0;
                end
                S_LOAD: if (accept) begin
                    if (rem_ge8) begin
                        asm_q[word_idx] <= bus.data_in;
                        remaining       <= remaining - LEN_W'(8);
                    end else begin
                        asm_q[word_idx] <= tail_word;
                        remaining       <= '0;
                        dom_done        <= 1'b1;
                    end
                    word_idx <= word_idx + 5'd1;
                end
                S_PAD: begin
                    if (!dom_done) begin
                        asm_q[word_idx][7:0] <= asm_q[word_idx][7:0] | dom;
                        dom_done             <= 1'b1;
                    end
                    asm_q[last_idx][63:56] <= asm_q[last_idx][63:56] | 8'h80;
                    last_q                 <= 1'b1;
                end
                S_COMMIT: if (push) begin
                    asm_q    <= '0;
                    word_idx <= '0;
                    last_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign push_entry = {asm_q, mode_q, last_q, out_len_q};

    block_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(push_entry),
        .pop      (bus.block_ready),
        .full     (full),
        .empty    (empty),
        .head     (head_entry)
    );

    assign bus.block_valid   = !empty;
    assign bus.block_data    = head_entry.data;
    assign bus.block_mode    = head_entry.mode;
    assign bus.block_last    = head_entry.last;
    assign bus.block_out_len = head_entry.out_len;

endmodule
